// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared state encoding and width helper for the bit-serial
//                adder.
//  Revision    : 1.0  initial release
// ============================================================================
package serial_adder_pkg;

    // Controller states; values are fixed so they can be matched in waves.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Bit-counter width: must be able to hold the value WIDTH itself.
    function automatic int calc_cw(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fa_bit.sv
`default_nettype none
// ============================================================================
//  Module      : fa_bit
//  Description : Combinational one-bit full adder built from two half adders
//                with the two partial carries merged by an OR.
//  Revision    : 1.0  initial release
// ============================================================================
module fa_bit (
    input  logic i_x,
    input  logic i_y,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);

    logic w_s0;
    logic w_c0;
    logic w_c1;

    // First stage adds the operand bits, second stage folds in the carry.
    half_adder u_ha0 (
        .i_x (i_x),
        .i_y (i_y),
        .o_s (w_s0),
        .o_c (w_c0)
    );

    half_adder u_ha1 (
        .i_x (w_s0),
        .i_y (i_ci),
        .o_s (o_s),
        .o_c (w_c1)
    );

    // The two partial carries can never both be set, so OR gives majority.
    assign o_co = w_c0 | w_c1;

endmodule
`default_nettype wire

// File: rtl/half_adder.sv
`default_nettype none
// ============================================================================
//  Module      : half_adder
//  Description : One-bit half adder (sum = x ^ y, carry = x & y).
//  Revision    : 1.0  initial release
// ============================================================================
module half_adder (
    input  logic i_x,
    input  logic i_y,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_x ^ i_y;
    assign o_c = i_x & i_y;

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : LSB-first bit-serial adder, one bit per clock, with a
//                start/busy/done handshake. {o_cout,o_sum} = A + B + CIN.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    localparam int CW = calc_cw(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_load;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    // Only WIDTH-1 partial bits need storing; the last bit goes straight
    // from the adder into the result register.
    logic [WIDTH-2:0] r_sum_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_cat;

    fa_bit u_fa (
        .i_x  (r_a_sh[0]),
        .i_y  (r_b_sh[0]),
        .i_ci (r_carry),
        .o_s  (w_s),
        .o_co (w_c)
    );

    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    assign w_sum_cat = {w_s, r_sum_sh};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; START is only honoured in IDLE and FIN.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                if (i_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand capture, serial shifting and result commit on the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum_sh <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else if (w_load) begin
            r_a_sh  <= i_a;
            r_b_sh  <= i_b;
            r_carry <= i_cin;
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_carry  <= w_c;
            r_cnt    <= r_cnt + CW'(1);
            r_sum_sh <= w_sum_cat[WIDTH-1:1];
            if (w_last) begin
                r_sum  <= w_sum_cat;
                r_cout <= w_c;
            end
        end
    end

    assign o_busy = (r_state == ST_RUN);
    assign o_done = (r_state == ST_FIN);
    assign o_sum  = r_sum;
    assign o_cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder with a result
//                scoreboard and handshake timing checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_cin;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_sum;
    logic             o_cout;

    int               n_checks;
    int               n_pass;
    int               n_done_seen;
    logic [WIDTH:0]   sb_q[$];
    logic [WIDTH:0]   m_hold;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (i_start),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_cin   (i_cin),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_sum   (o_sum),
        .o_cout  (o_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic cin);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    endfunction

    // Scoreboard side: pop on every DONE, and verify the held result in RUN.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_busy) begin
                check_eq("hold_in_run", {o_cout, o_sum}, m_hold);
                check_eq("busy_done_excl", o_done, 1'b0);
            end
            if (o_done) begin
                n_done_seen++;
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_done", o_done, 1'b0);
                end else begin
                    m_hold = sb_q.pop_front();
                    check_eq("done_result", {o_cout, o_sum}, m_hold);
                end
            end
        end
    end

    // One complete operation with latency and BUSY-length checks.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
        int cycles;
        int busy_cycles;
        @(negedge clk);
        i_start = 1'b1;
        i_a     = a;
        i_b     = b;
        i_cin   = cin;
        sb_q.push_back(ref_add(a, b, cin));
        @(negedge clk);
        i_start     = 1'b0;
        i_a         = WIDTH'($urandom);
        i_b         = WIDTH'($urandom);
        i_cin       = 1'($urandom);
        cycles      = 0;
        busy_cycles = 0;
        while (!o_done && cycles < WIDTH + 4) begin
            if (o_busy) busy_cycles++;
            @(negedge clk);
            cycles++;
        end
        check_eq("latency", cycles, WIDTH);
        check_eq("busy_len", busy_cycles, WIDTH);
    endtask

    initial begin
        int c1;
        int c2;
        int done_before;
        n_checks    = 0;
        n_pass      = 0;
        n_done_seen = 0;
        m_hold      = '0;
        i_start     = 1'b0;
        i_a         = '0;
        i_b         = '0;
        i_cin       = 1'b0;
        rst_n       = 1'b1;
        #3 rst_n    = 1'b0;
        #2;
        check_eq("rst_busy", o_busy, 1'b0);
        check_eq("rst_done", o_done, 1'b0);
        check_eq("rst_result", {o_cout, o_sum}, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        do_op(8'h5A, 8'h3C, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b1);

        // START held high: ignored in RUN, accepted in FIN.
        @(negedge clk);
        i_start = 1'b1;
        i_a     = 8'h10;
        i_b     = 8'h20;
        i_cin   = 1'b0;
        sb_q.push_back(ref_add(8'h10, 8'h20, 1'b0));
        @(negedge clk);
        i_a = 8'h01;
        i_b = 8'h01;
        c1  = 0;
        while (!o_done && c1 < WIDTH + 4) begin
            @(negedge clk);
            c1++;
        end
        check_eq("b2b_first_lat", c1, WIDTH);
        sb_q.push_back(ref_add(8'h01, 8'h01, 1'b0));
        @(negedge clk);
        i_start = 1'b0;
        c2      = 1;
        while (!o_done && c2 < WIDTH + 6) begin
            @(negedge clk);
            c2++;
        end
        check_eq("b2b_gap", c2, WIDTH + 1);

        // Leave a known non-zero result visible, then abort mid-RUN.
        do_op(8'hFF, 8'hFF, 1'b1);
        @(negedge clk);
        i_start = 1'b1;
        i_a     = 8'h55;
        i_b     = 8'hAA;
        i_cin   = 1'b0;
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("abort_in_run", o_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_busy", o_busy, 1'b0);
        check_eq("abort_done", o_done, 1'b0);
        check_eq("abort_result", {o_cout, o_sum}, '0);
        m_hold = '0;
        @(negedge clk);
        rst_n       = 1'b1;
        done_before = n_done_seen;
        repeat (WIDTH + 4) @(negedge clk);
        check_eq("no_done_after_abort", n_done_seen, done_before);
        do_op(8'h12, 8'h34, 1'b1);

        // Random operand triples with random idle gaps.
        for (int i = 0; i < 1000; i++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        check_eq("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
